// File: rtl/pixel_write_arbiter_pkg.sv
// Shared constants for the pixel write arbiter: MasterFSM state encodings,
// requester indices, per-state write masks and the arbiter FSM state type.
package pixel_write_arbiter_pkg;

    localparam int unsigned CS_W = 5;

    localparam logic [CS_W-1:0] STARTSCREEN = 5'd1;
    localparam logic [CS_W-1:0] RECORD      = 5'd2;
    localparam logic [CS_W-1:0] PLAYBACK    = 5'd3;

    localparam int unsigned REQ_STARTSCREEN = 0;
    localparam int unsigned REQ_RESETSCREEN = 1;
    localparam int unsigned REQ_NOTEBLOCK   = 2;

    localparam logic [2:0] MASK_STARTSCREEN = 3'b001;
    localparam logic [2:0] MASK_RECORD      = 3'b010;
    localparam logic [2:0] MASK_PLAYBACK    = 3'b110;

    typedef enum logic [0:0] {StIdle, StOwn} arb_state_e;

    function automatic logic [2:0] mask_for_state(input logic [CS_W-1:0] cs);
        logic [2:0] m;
        m = 3'b000;
        if (cs == STARTSCREEN) m = MASK_STARTSCREEN;
        else if (cs == RECORD) m = MASK_RECORD;
        else if (cs == PLAYBACK) m = MASK_PLAYBACK;
        return m;
    endfunction

endpackage

// File: rtl/pixel_write_arbiter_rr_priority_pick.sv
// Round-robin pick: first eligible requester at or after the pointer,
// wrapping modulo NUM_REQ. Purely combinational.
module rr_priority_pick #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_eligible,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    always_comb begin
        logic [IDX_W-1:0] w_cand;
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_cand   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_cand = IDX_W'((32'(i_ptr) + k) % NUM_REQ);
            if (!o_valid && i_eligible[w_cand]) begin
                o_valid          = 1'b1;
                o_idx            = w_cand;
                o_onehot[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Arbitrates the single vga_adapter pixel port between three pixel sources with
// state masking, round-robin grants and sprite locks. Optional macro PIXEL_CLIP_EN.
module pixel_write_arbiter
    import pixel_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 8,
    parameter int unsigned COLOUR_W = 24,
    parameter int unsigned STATE_W  = 5,
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120
) (
    input  logic                        CLOCK_50,
    input  logic                        resetn,
    input  logic [STATE_W-1:0]          currentState,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          lock,
    input  logic [NUM_REQ*X_W-1:0]      reqX,
    input  logic [NUM_REQ*Y_W-1:0]      reqY,
    input  logic [NUM_REQ*COLOUR_W-1:0] reqColour,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        plot,
    output logic [X_W-1:0]              screenX,
    output logic [Y_W-1:0]              screenY,
    output logic [COLOUR_W-1:0]         colour,
    output logic [1:0]                  owner,
    output logic                        locked
);

    arb_state_e r_state, w_state_next;
    logic [1:0]          r_ptr, w_ptr_next, r_owner, w_owner_next;
    logic [STATE_W-1:0]  r_prev_cs;
    logic [NUM_REQ-1:0]  w_mask, w_eligible, w_pick_onehot;
    logic [1:0]          w_pick_ptr, w_pick_idx, w_win_idx, w_owner_inc, w_win_inc;
    logic                w_pick_valid, w_exit_own, w_idle_form, w_xfer, w_win_lock;
    logic                w_in_range, w_plot_d;
    logic [X_W-1:0]      w_sel_x;
    logic [Y_W-1:0]      w_sel_y;
    logic [COLOUR_W-1:0] w_sel_c;
    logic                r_plot;
    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
    logic [COLOUR_W-1:0] r_colour;

    assign w_mask     = NUM_REQ'(mask_for_state(CS_W'(currentState)));
    assign w_eligible = req & w_mask;

    // Any exit condition turns this cycle into an IDLE-style arbitration from owner+1.
    assign w_exit_own = (r_state == StOwn) &&
                        ((currentState != r_prev_cs) || !w_mask[r_owner] ||
                         (!req[r_owner] && !lock[r_owner]));
    assign w_idle_form = (r_state == StIdle) || w_exit_own;

    assign w_owner_inc = (r_owner == 2'(NUM_REQ - 1)) ? 2'd0 : r_owner + 2'd1;
    assign w_pick_ptr  = (r_state == StOwn) ? w_owner_inc : r_ptr;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (2)
    ) u_pick (
        .i_eligible (w_eligible),
        .i_ptr      (w_pick_ptr),
        .o_onehot   (w_pick_onehot),
        .o_idx      (w_pick_idx),
        .o_valid    (w_pick_valid)
    );

    assign w_win_idx  = w_idle_form ? w_pick_idx : r_owner;
    assign w_win_inc  = (w_win_idx == 2'(NUM_REQ - 1)) ? 2'd0 : w_win_idx + 2'd1;
    assign w_win_lock = lock[w_win_idx];
    assign w_xfer     = |ack;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state   <= StIdle;
            r_ptr     <= 2'd0;
            r_owner   <= 2'd0;
            r_prev_cs <= '0;
        end else begin
            r_state   <= w_state_next;
            r_ptr     <= w_ptr_next;
            r_owner   <= w_owner_next;
            r_prev_cs <= currentState;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_owner_next = r_owner;
        if (w_idle_form) begin
            w_state_next = StIdle;
            if (r_state == StOwn) w_ptr_next = w_owner_inc;
            if (w_xfer) begin
                w_owner_next = w_win_idx;
                if (w_win_lock) w_state_next = StOwn;
                else            w_ptr_next   = w_win_inc;
            end
        end else if (w_xfer && !w_win_lock) begin
            w_state_next = StIdle;
            w_ptr_next   = w_owner_inc;
        end
    end

    always_comb begin
        ack = '0;
        if (w_idle_form) ack = w_pick_onehot;
        else             ack[r_owner] = w_eligible[r_owner];
        locked = (r_state == StOwn);
        owner  = r_owner;
    end

    assign w_sel_x = reqX[w_win_idx*X_W +: X_W];
    assign w_sel_y = reqY[w_win_idx*Y_W +: Y_W];
    assign w_sel_c = reqColour[w_win_idx*COLOUR_W +: COLOUR_W];

`ifdef PIXEL_CLIP_EN
    // Off-screen pixels are consumed but never reach the adapter.
    assign w_in_range = (32'(w_sel_x) < SCREEN_W) && (32'(w_sel_y) < SCREEN_H);
`else
    assign w_in_range = 1'b1;
`endif

    assign w_plot_d = w_xfer && w_in_range && w_pick_valid_or_own();

    function automatic logic w_pick_valid_or_own();
        return w_pick_valid || !w_idle_form;
    endfunction

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_plot   <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
        end else begin
            r_plot <= w_plot_d;
            if (w_plot_d) begin
                r_x      <= w_sel_x;
                r_y      <= w_sel_y;
                r_colour <= w_sel_c;
            end
        end
    end

    assign plot    = r_plot;
    assign screenX = r_x;
    assign screenY = r_y;
    assign colour  = r_colour;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Directed self-checking bench for pixel_write_arbiter: masking, round-robin,
// locks, state-change lock drop, async reset and the optional clip behaviour.
module tb_pixel_write_arbiter;
    import pixel_write_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  cs;
    logic [2:0]  req, lock, ack;
    logic [23:0] rx, ry;
    logic [71:0] rc;
    logic        plot, locked;
    logic [7:0]  screenX, screenY;
    logic [23:0] colour;
    logic [1:0]  owner;

    logic [7:0]  src_x [3];
    logic [7:0]  src_y [3];
    logic [23:0] src_c [3];
    logic [7:0]  last_x, last_y;
    logic [23:0] last_c;
    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pixel_write_arbiter dut (
        .CLOCK_50     (clk),
        .resetn       (resetn),
        .currentState (cs),
        .req          (req),
        .lock         (lock),
        .reqX         (rx),
        .reqY         (ry),
        .reqColour    (rc),
        .ack          (ack),
        .plot         (plot),
        .screenX      (screenX),
        .screenY      (screenY),
        .colour       (colour),
        .owner        (owner),
        .locked       (locked)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < 3; i++) begin
            rx[i*8 +: 8]   = src_x[i];
            ry[i*8 +: 8]   = src_y[i];
            rc[i*24 +: 24] = src_c[i];
        end
    endtask

    function automatic int idx_of(input logic [2:0] oh);
        return oh[2] ? 2 : (oh[1] ? 1 : 0);
    endfunction

    // Called just after a negedge with inputs set; returns at the next negedge.
    task automatic cycle(input logic [2:0] exp_ack, input logic exp_plot, input string tag);
        int w;
        pack();
        #1;
        chk({tag, ".ack"}, 32'(ack), 32'(exp_ack));
        w = idx_of(exp_ack);
        @(posedge clk);
        #1;
        chk({tag, ".plot"}, 32'(plot), 32'(exp_plot));
        if (exp_plot) begin
            last_x = src_x[w];
            last_y = src_y[w];
            last_c = src_c[w];
        end
        chk({tag, ".x"}, 32'(screenX), 32'(last_x));
        chk({tag, ".y"}, 32'(screenY), 32'(last_y));
        chk({tag, ".colour"}, 32'(colour), 32'(last_c));
        if (exp_ack != 3'b000) begin
            src_x[w] = src_x[w] + 8'd1;
            src_y[w] = src_y[w] + 8'd1;
            src_c[w] = src_c[w] + 24'd1;
        end
        @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0;
        cs     = STARTSCREEN;
        req    = 3'b000;
        lock   = 3'b000;
        for (int i = 0; i < 3; i++) begin
            src_x[i] = 8'(10 + 40 * i);
            src_y[i] = 8'(5 + 30 * i);
            src_c[i] = {8'(i + 1), 16'h00a0};
        end
        last_x = '0;
        last_y = '0;
        last_c = '0;
        pack();
        #12;
        chk("rst.plot", 32'(plot), 32'd0);
        chk("rst.x", 32'(screenX), 32'd0);
        chk("rst.colour", 32'(colour), 32'd0);
        chk("rst.owner", 32'(owner), 32'd0);
        chk("rst.locked", 32'(locked), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Unmasked state: nobody may write.
        cs  = 5'd0;
        req = 3'b111;
        cycle(3'b000, 1'b0, "nomask");

        // 1) STARTSCREEN: only source 0, every cycle.
        cs = STARTSCREEN;
        cycle(3'b001, 1'b1, "t1a");
        cycle(3'b001, 1'b1, "t1b");
        cycle(3'b001, 1'b1, "t1c");

        // 2) PLAYBACK alternation, pointer starts at 1.
        cs  = PLAYBACK;
        req = 3'b110;
        cycle(3'b010, 1'b1, "t2a");
        cycle(3'b100, 1'b1, "t2b");
        cycle(3'b010, 1'b1, "t2c");
        cycle(3'b100, 1'b1, "t2d");
        cycle(3'b010, 1'b1, "t2e");

        // 3) Locked 4-pixel sprite from source 2 while source 1 waits.
        lock = 3'b100;
        cycle(3'b100, 1'b1, "t3a");
        chk("t3a.locked", 32'(locked), 32'd1);
        chk("t3a.owner", 32'(owner), 32'd2);
        cycle(3'b100, 1'b1, "t3b");
        cycle(3'b100, 1'b1, "t3c");
        lock = 3'b000;
        cycle(3'b100, 1'b1, "t3d");
        chk("t3d.locked", 32'(locked), 32'd0);
        cycle(3'b010, 1'b1, "t3e");

        // 4) State change mid-burst drops the lock.
        lock = 3'b100;
        cycle(3'b100, 1'b1, "t4a");
        cycle(3'b100, 1'b1, "t4b");
        chk("t4b.locked", 32'(locked), 32'd1);
        cs = RECORD;
        cycle(3'b010, 1'b1, "t4c");
        chk("t4c.locked", 32'(locked), 32'd0);
        cycle(3'b010, 1'b1, "t4d");
        cycle(3'b010, 1'b1, "t4e");

        // 5) Async reset during a locked burst.
        cs = PLAYBACK;
        pack();
        #1;
        chk("t5.ack", 32'(ack), 32'b100);
        @(posedge clk);
        #1;
        chk("t5.locked_pre", 32'(locked), 32'd1);
        chk("t5.plot_pre", 32'(plot), 32'd1);
        chk("t5.owner_pre", 32'(owner), 32'd2);
        #1 resetn = 1'b0;
        #1;
        chk("t5.plot_rst", 32'(plot), 32'd0);
        chk("t5.owner_rst", 32'(owner), 32'd0);
        chk("t5.locked_rst", 32'(locked), 32'd0);
        chk("t5.x_rst", 32'(screenX), 32'd0);
        last_x = '0;
        last_y = '0;
        last_c = '0;
        @(negedge clk);
        req = 3'b000;
        @(negedge clk);
        resetn = 1'b1;
        req    = 3'b110;
        lock   = 3'b000;
        cycle(3'b010, 1'b1, "t5_restart");

        // 6) Off-screen pixel followed by the last on-screen pixel.
        cs       = STARTSCREEN;
        req      = 3'b001;
        src_x[0] = 8'd160;
        src_y[0] = 8'd5;
`ifdef PIXEL_CLIP_EN
        cycle(3'b001, 1'b0, "t6_oob");
`else
        cycle(3'b001, 1'b1, "t6_oob");
`endif
        src_x[0] = 8'd159;
        src_y[0] = 8'd119;
        cycle(3'b001, 1'b1, "t6_edge");
        chk("t6.x", 32'(screenX), 32'd159);
        chk("t6.y", 32'(screenY), 32'd119);

        req = 3'b000;
        cycle(3'b000, 1'b0, "idle_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
